// File: rtl/test_monitor.sv
// -----------------------------------------------------------------------------
// test_monitor
//   Supervises a self-checking CPU test run. It holds the monitored harts in
//   reset for RST_CYCLES clocks after rst is released. It then counts run
//   cycles and watches each hart's halt flag together with its a0/x10 result.
//   The test passes once every hart has been seen halted with result zero. It
//   fails as soon as any hart is seen halted with a nonzero result. PASS and
//   FAIL are terminal until the next rst.
//
//   Optional feature: define TEST_MONITOR_TIMEOUT_EN to enable a watchdog
//   that fails the run once cycles reaches TIMEOUT.
//
// Parameters
//   NUM_HARTS  number of monitored harts (1..8)
//   XLEN       width of each hart's result value
//   RST_CYCLES clocks cpu_rst_n is held low after rst deasserts (1..255)
//   TIMEOUT    watchdog limit in run cycles (used only with the macro)
//
// Ports
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   halted     per-hart halt level, bit i = hart i
//   result     per-hart result, hart i at [i*XLEN +: XLEN]
//   cpu_rst_n  active-low reset to the monitored CPUs
//   done       test finished (sticky)
//   pass       every hart halted with result zero (sticky)
//   fail       a hart halted with a nonzero result, or the watchdog fired (sticky)
//   timed_out  the failure came from the watchdog (sticky)
//   fail_hart  lowest failing hart index, 0 when no hart failed
//   cycles     run-cycle count, saturating at 32'hFFFF_FFFF
// -----------------------------------------------------------------------------
module test_monitor #(
  parameter int NUM_HARTS  = 1,
  parameter int XLEN       = 32,
  parameter int RST_CYCLES = 2,
  parameter int TIMEOUT    = 100000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_HARTS-1:0]      halted,
  input  logic [NUM_HARTS*XLEN-1:0] result,
  output logic                      cpu_rst_n,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic                      timed_out,
  output logic [2:0]                fail_hart,
  output logic [31:0]               cycles
);

  typedef enum logic [1:0] {HOLD, RUN, PASS, FAIL} state_t;

  localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

  state_t               state;
  logic [7:0]           hold_cnt;
  logic [NUM_HARTS-1:0] seen;       // halts latched during RUN

  logic [NUM_HARTS-1:0] bad;
  logic [NUM_HARTS-1:0] seen_next;
  logic                 any_bad;
  logic                 all_halted;
  logic [2:0]           bad_idx;

  // Evaluate this cycle's sample. A hart counts as failing only while its
  // halt flag is high, because result is meaningless before the hart halts.
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    bad     = '0;
    bad_idx = 3'd0;
    for (int i = 0; i < NUM_HARTS; i++) begin
      bad[i] = halted[i] && (result[i*XLEN +: XLEN] != '0);
    end
    // Scan from the top down so that the lowest failing index wins.
    for (int i = NUM_HARTS - 1; i >= 0; i--) begin
      if (bad[i]) bad_idx = 3'(i);
    end
    any_bad    = |bad;
    seen_next  = seen | halted;
    all_halted = &seen_next;
  end

`ifdef TEST_MONITOR_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);
  logic wd_hit;
  assign wd_hit = (cycles >= TIMEOUT_W);
`else
  // No watchdog in this build, so a timeout can never be reported.
  assign timed_out = 1'b0;
`endif

  // NOTE: state is updated with non-blocking assignments, so every branch
  // reads the pre-edge values. The reset branch is asynchronous, which lets
  // rst clear the outputs between clock edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= HOLD;
      hold_cnt  <= 8'd0;
      seen      <= '0;
      cpu_rst_n <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      fail_hart <= 3'd0;
      cycles    <= 32'd0;
`ifdef TEST_MONITOR_TIMEOUT_EN
      timed_out <= 1'b0;
`endif
    end else begin
      case (state)
        HOLD: begin
          if (hold_cnt == RST_LAST) begin
            state     <= RUN;
            cpu_rst_n <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        RUN: begin
          if (cycles != 32'hFFFF_FFFF) cycles <= cycles + 32'd1;
          seen <= seen_next;
          // A hart failure beats completion; completion beats the watchdog.
          if (any_bad) begin
            state     <= FAIL;
            done      <= 1'b1;
            fail      <= 1'b1;
            fail_hart <= bad_idx;
          end else if (all_halted) begin
            state <= PASS;
            done  <= 1'b1;
            pass  <= 1'b1;
          end
`ifdef TEST_MONITOR_TIMEOUT_EN
          else if (wd_hit) begin
            state     <= FAIL;
            done      <= 1'b1;
            fail      <= 1'b1;
            timed_out <= 1'b1;
          end
`endif
        end
        default: ; // PASS and FAIL hold everything until rst
      endcase
    end
  end

endmodule

// File: tb/tb_test_monitor.sv
// -----------------------------------------------------------------------------
// tb_test_monitor
//   Randomized bench for test_monitor (4 harts, 16-bit results, 3 reset
//   cycles, TIMEOUT 200). Each episode builds a per-cycle halt/result schedule.
//   A reference model derives the outcome from the schedule as a whole:
//     - the first cycle at which any hart is seen failing,
//     - the cycle at which the last hart is first seen halted,
//     - the watchdog limit, when the watchdog is built in.
//   The expected outcome is queued, and a separate monitor checks it when
//   done rises. Works with or without TEST_MONITOR_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_test_monitor;

  localparam int NH  = 4;
  localparam int XW  = 16;
  localparam int RC  = 3;
  localparam int TO  = 200;
  localparam int LEN = 1000;
  localparam int INF = 1 << 30;

  typedef struct {
    logic        pass;
    logic        fail;
    logic        to;
    logic [2:0]  fh;
    logic [31:0] cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NH-1:0]     halted = '0;
  logic [NH*XW-1:0]  result = '0;
  logic              cpu_rst_n, done, pass, fail, timed_out;
  logic [2:0]        fail_hart;
  logic [31:0]       cycles;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];
  logic done_q = 1'b0;

  logic [NH-1:0]    hv[LEN];
  logic [NH*XW-1:0] rv[LEN];

  test_monitor #(
    .NUM_HARTS(NH), .XLEN(XW), .RST_CYCLES(RC), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .halted(halted), .result(result),
    .cpu_rst_n(cpu_rst_n), .done(done), .pass(pass), .fail(fail),
    .timed_out(timed_out), .fail_hart(fail_hart), .cycles(cycles)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: when done rises, compare the DUT outcome with the oldest entry.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && done && !done_q) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 32'(done), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pass",      32'(pass),      32'(e.pass));
          check("fail",      32'(fail),      32'(e.fail));
          check("timed_out", 32'(timed_out), 32'(e.to));
          check("fail_hart", 32'(fail_hart), 32'(e.fh));
          check("cycles",    cycles,         e.cyc);
          check("pass_and_fail_exclusive", 32'(pass & fail), 32'd0);
        end
      end
      done_q = done;
    end
  end

  // Reference outcome computed from the whole schedule.
  function automatic logic model(input int len, output exp_t e);
    int fk = INF, fh = 0, pk = 0, tk = INF;
    for (int h = 0; h < NH; h++) begin
      int first = INF;
      for (int k = 0; k < len; k++)
        if (hv[k][h] && first == INF) first = k;
      if (first > pk) pk = first;
    end
    for (int k = 0; k < len && fk == INF; k++)
      for (int h = NH - 1; h >= 0; h--)
        if (hv[k][h] && rv[k][h*XW +: XW] != '0) begin fk = k; fh = h; end
`ifdef TEST_MONITOR_TIMEOUT_EN
    tk = TO;
`endif
    e = '{pass: 1'b0, fail: 1'b0, to: 1'b0, fh: 3'd0, cyc: 32'd0};
    if (fk != INF && fk <= pk && fk <= tk) begin
      e.fail = 1'b1; e.fh = 3'(fh); e.cyc = 32'(fk + 1);
    end else if (pk != INF && pk <= tk && pk < len) begin
      e.pass = 1'b1; e.cyc = 32'(pk + 1);
    end else if (tk != INF && tk < len) begin
      e.fail = 1'b1; e.to = 1'b1; e.cyc = 32'(tk + 1);
    end else begin
      return 1'b0;
    end
    return 1'b1;
  endfunction

  // kind 0: random halts, 1: never halt, 2: async reset mid-RUN,
  // 3: all harts halt exactly at the watchdog limit.
  task automatic run_episode(input int kind);
    int   len;
    logic ends;
    exp_t e;
    for (int k = 0; k < LEN; k++) begin
      hv[k] = '0;
      rv[k] = {$urandom, $urandom};
    end
    case (kind)
      0: begin
        int window = ($urandom_range(0, 1) != 0) ? 8 : 60;
        len = 80;
        for (int h = 0; h < NH; h++) begin
          int a = $urandom_range(0, window);
          int d = $urandom_range(1, 4);
          logic [XW-1:0] val = ($urandom_range(0, 3) != 0) ? '0 : XW'($urandom_range(1, 65535));
          for (int k = a; k < a + d; k++) begin
            hv[k][h] = 1'b1;
            rv[k][h*XW +: XW] = val;
          end
        end
      end
      1: begin
`ifdef TEST_MONITOR_TIMEOUT_EN
        len = TO + 10;
`else
        len = LEN;
`endif
      end
      2: len = 20;
      default: begin
        int bh = $urandom_range(0, 2 * NH - 1);
        len = TO + 10;
        for (int h = 0; h < NH; h++) begin
          hv[TO][h] = 1'b1;
          rv[TO][h*XW +: XW] = (h == bh) ? XW'(9) : '0;
        end
      end
    endcase
    ends = (kind != 2) && model(len, e);
    if (ends) sb.push_back(e);

    // Asynchronous reset between edges, with junk on the inputs.
    @(negedge clk);
    #2;
    rst    = 1'b1;
    halted = NH'($urandom);
    result = {$urandom, $urandom};
    #1;
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_done",      32'(done),      32'd0);
    check("rst_pass_fail", 32'({pass, fail, timed_out}), 32'd0);
    check("rst_fail_hart", 32'(fail_hart), 32'd0);
    check("rst_cycles",    cycles,         32'd0);
    @(negedge clk);
    rst    = 1'b0;
    halted = '1;                // must be ignored in HOLD
    result = '1;
    for (int i = 1; i <= RC; i++) begin
      @(negedge clk);
      check("hold_cpu_rst_n", 32'(cpu_rst_n), 32'(i == RC));
    end
    check("run_start_cycles", cycles, 32'd0);
    check("hold_no_done", 32'(done), 32'd0);

    for (int k = 0; k < len; k++) begin
      halted = hv[k];
      result = rv[k];
      if (kind == 2 && k == 10) begin
        check("midrun_cycles", cycles, 32'd10);
        #2;
        rst = 1'b1;
        #1;
        check("midrun_rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("midrun_rst_cycles",    cycles,         32'd0);
        check("midrun_rst_done",      32'(done),      32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 1; i <= RC; i++) begin
          @(negedge clk);
          check("rehold_cpu_rst_n", 32'(cpu_rst_n), 32'(i == RC));
        end
        check("rehold_cycles", cycles, 32'd0);
        return;
      end
      @(negedge clk);
      if (done) break;
    end
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    if (ends) begin
      check("done_seen", 32'(done), 32'd1);
      // Terminal state must ignore further halts and freeze cycles.
      for (int i = 0; i < 4; i++) begin
        halted = NH'($urandom);
        result = {$urandom, $urandom};
        @(negedge clk);
      end
      check("term_cycles", cycles, e.cyc);
      check("term_flags",  32'({done, pass, fail, timed_out}), 32'({1'b1, e.pass, e.fail, e.to}));
      check("term_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
    end else begin
      check("no_end_done",   32'(done),  32'd0);
      check("no_end_fail",   32'(fail),  32'd0);
      check("no_end_cycles", cycles,     32'(len));
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    for (int n = 0; n < 25; n++) run_episode(0);
    run_episode(1);
    run_episode(2);
    run_episode(3);
    run_episode(3);
    for (int n = 0; n < 5; n++) run_episode(0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", n_errors);
    $fatal(1, "bench time limit");
  end

endmodule
